// File: rtl/laser_pkg.sv
// Shared types and sizing helpers for the averaging laser distance meter.
//   state_t          : controller state encoding
//   cnt_w / acc_w    : round-trip counter and accumulator widths
//   def_timeout      : largest round-trip count a DW-wide meter can represent
package laser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT,
        GAP,
        DONE
    } state_t;

    function automatic int cnt_w(input int dw);
        return dw + 1;
    endfunction

    // Sum of 2^navg_log2 samples, each at most DW bits, never overflows this.
    function automatic int acc_w(input int dw, input int navg_log2);
        return dw + navg_log2;
    endfunction

    function automatic int def_timeout(input int dw);
        return (1 << (dw + 1)) - 1;
    endfunction

    localparam int DEF_DW          = 16;
    localparam int DEF_TIMEOUT_CYC = def_timeout(DEF_DW);

endpackage

// File: rtl/laser_rt_ctr.sv
// Round-trip cycle counter.
//   Clk, Rst    : clock, synchronous active-low reset
//   load        : restart the count at 1 (takes priority over inc)
//   inc         : advance the count by one
//   cnt         : current round-trip count
//   at_timeout  : cnt has reached TIMEOUT_CYC
module laser_rt_ctr #(
    parameter int CW          = 17,
    parameter int TIMEOUT_CYC = (1 << CW) - 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          load,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_timeout
);

    always_ff @(posedge Clk) begin
        if (!Rst)
            cnt <= '0;
        else if (load)
            cnt <= CW'(1);
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign at_timeout = (cnt == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/laser_dist_avg.sv
// Averaging laser distance meter. A button press fires 2^NAVG_LOG2 shots,
// each timed from laser start to echo; the one-way distances are averaged.
//   Clk, Rst : clock, synchronous active-low reset
//   B        : start button (only looked at while idle)
//   S        : reflection sensor (only looked at in WAIT and GAP)
//   L        : laser enable
//   D        : averaged distance in cycles, all ones on timeout
//   Valid    : one-cycle strobe after D is loaded
//   Busy     : measurement in progress
//   Timeout  : last measurement was abandoned
module laser_dist_avg
    import laser_pkg::*;
#(
    parameter int DW          = 16,
    parameter int PULSE_CYC   = 1,
    parameter int TIMEOUT_CYC = def_timeout(DW),
    parameter int NAVG_LOG2   = 0
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          B,
    input  logic          S,
    output logic          L,
    output logic [DW-1:0] D,
    output logic          Valid,
    output logic          Busy,
    output logic          Timeout
);

    localparam int CW = cnt_w(DW);
    localparam int AW = acc_w(DW, NAVG_LOG2);
    // Keep the shot index at least one bit wide even for single-shot builds.
    localparam int SW = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
    localparam logic [SW-1:0] LAST_SHOT = SW'((1 << NAVG_LOG2) - 1);

    state_t        state, nstate;
    logic [CW-1:0] cnt;
    logic          at_to;
    logic          ctr_load, ctr_inc;
    logic          start, acc_add, shot_adv, finish, abort;
    logic [SW-1:0] shot_idx;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;

    laser_rt_ctr #(
        .CW          (CW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ctr (
        .Clk        (Clk),
        .Rst        (Rst),
        .load       (ctr_load),
        .inc        (ctr_inc),
        .cnt        (cnt),
        .at_timeout (at_to)
    );

    // One-way distance is half the round trip.
    assign acc_sum = acc + AW'(cnt[CW-1:1]);

    always_ff @(posedge Clk) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate   = state;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        start    = 1'b0;
        acc_add  = 1'b0;
        shot_adv = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (B) begin
                    start    = 1'b1;
                    ctr_load = 1'b1;
                    nstate   = FIRE;
                end
            end
            FIRE: begin
                // cnt starts at 1 on entry, so it doubles as the pulse timer.
                ctr_inc = 1'b1;
                if (cnt == CW'(PULSE_CYC))
                    nstate = WAIT;
            end
            WAIT: begin
                // An echo on the timeout edge still counts as a valid shot.
                if (S) begin
                    acc_add = 1'b1;
                    if (shot_idx == LAST_SHOT) begin
                        finish = 1'b1;
                        nstate = DONE;
                    end else begin
                        shot_adv = 1'b1;
                        nstate   = GAP;
                    end
                end else if (at_to) begin
                    abort  = 1'b1;
                    nstate = DONE;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            GAP: begin
                // Let the previous echo clear before firing again.
                if (!S) begin
                    ctr_load = 1'b1;
                    nstate   = FIRE;
                end
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            shot_idx <= '0;
            acc      <= '0;
            D        <= '0;
            Timeout  <= 1'b0;
        end else begin
            if (start) begin
                shot_idx <= '0;
                acc      <= '0;
                Timeout  <= 1'b0;
            end
            if (acc_add)
                acc <= acc_sum;
            if (shot_adv)
                shot_idx <= shot_idx + 1'b1;
            // Dividing by the power-of-two shot count is just dropping low bits.
            if (finish)
                D <= acc_sum[AW-1:NAVG_LOG2];
            if (abort) begin
                D       <= '1;
                Timeout <= 1'b1;
            end
        end
    end

    assign L     = (state == FIRE);
    assign Valid = (state == DONE);
    assign Busy  = (state != IDLE);

endmodule

// File: doc/laser_dist_avg.md
# laser_dist_avg

Parametrised laser distance measurer, successor to the single-shot 16-bit laser timer. On a button press it fires the laser for a configurable pulse, counts clock cycles until the reflection sensor fires, and repeats for 2^NAVG_LOG2 shots. It averages the one-way distances (round-trip/2), reports a timeout when no echo arrives, and publishes the result with a one-cycle valid strobe. It sits between the button/sensor front end and the distance display/logging logic.

## Interface
- DW, 16: distance output width; the round-trip counter is DW+1 bits.
- PULSE_CYC, 1: laser-on cycles per shot (≥1).
- TIMEOUT_CYC, 2^(DW+1)-1: round-trip count at which a shot is abandoned (PULSE_CYC < TIMEOUT_CYC ≤ 2^(DW+1)-1).
- NAVG_LOG2, 0: log2 of shots averaged per measurement (0..4).
- Clk  in  1  single clock; all state changes on the rising edge.
- Rst  in  1  reset, synchronous, active-low.
- B  in  1  start button; sampled only in IDLE.
- S  in  1  reflection sensor; sampled only in WAIT and GAP.
- L  out  1  laser enable.
- D  out  DW  averaged distance in cycles; held until the next completion.
- Valid  out  1  one-cycle strobe in the cycle after D updates.
- Busy  out  1  high in every state except IDLE.
- Timeout  out  1  high when the last measurement aborted; cleared when B is accepted.

## Operation
- Reset (Rst=0 at an edge): state IDLE, L=0, D=0, Valid=0, Busy=0, Timeout=0, counters and accumulator 0. This applies in any state, including mid-shot. The laser is off from the cycle after that edge.
- States: IDLE, FIRE, WAIT, GAP, DONE.
- IDLE: B=1 at an edge → FIRE. Shot index=0, accumulator=0, cnt=1, Timeout=0.
- FIRE: L=1 for exactly PULSE_CYC cycles, then WAIT. cnt increments every edge. S is ignored, so an echo during the pulse is not counted.
- WAIT: L=0.
  - S=0 and cnt<TIMEOUT_CYC: cnt increments.
  - S=1: sample=cnt>>1 is added to the accumulator. If this was the last shot → DONE. Otherwise shot index+1, then → GAP.
  - S=0 and cnt==TIMEOUT_CYC: abort the whole measurement. D=all ones, Timeout=1 → DONE.
  - S=1 and the timeout condition on the same edge: S wins.
- GAP: wait until S=0 is sampled. Then → FIRE with cnt=1. This state has no timeout.
- DONE: Valid=1 for one cycle → IDLE. On normal completion D = accumulator >> NAVG_LOG2, truncated to DW bits, loaded on the edge entering DONE.
- Round-trip R is the number of edges from the edge accepting B (or leaving GAP) to the edge sampling S=1. cnt equals R at that edge, so the per-shot distance is floor(R/2).
- Accumulator is DW+NAVG_LOG2 bits wide; it cannot overflow.
- B while Busy is ignored, with no queuing.

## Timing
- L rises the cycle after the accepting edge.
- Valid is high in the cycle after the edge that samples the final S=1, or the timeout edge.
- Single-shot latency from the B edge to the Valid edge is R+1 cycles.
- Consecutive measurements: B accepted at the edge after DONE earliest, i.e. the first edge in IDLE.
- Outputs are registered, or decoded from the registered state only. No combinational path from B or S to any output.

## Structure
- Package laser_pkg:
  - state enum (IDLE, FIRE, WAIT, GAP, DONE)
  - width helper for counter (DW+1) and accumulator (DW+NAVG_LOG2)
  - default TIMEOUT_CYC constant
- Sub-module laser_rt_ctr: DW+1-bit round-trip counter.
  - Inputs: load-1, increment enable.
  - Outputs: count and a timeout-compare flag.
- The top level holds the FSM, shot index, accumulator and output registers.

## Test plan
- Parameters at defaults. Hold Rst=0 for 2 edges. Pulse B. Raise S 20 edges after the accepting edge → L high for 1 cycle; D=10, Valid single-cycle, Timeout=0, Busy low after DONE.
- NAVG_LOG2=2. Four shots with R=20, 21, 30, 10, with S dropped between shots → samples 10, 10, 15, 5; D=10; exactly one Valid.
- TIMEOUT_CYC=50, S never rises → Valid at the 51st edge after B; D=16'hFFFF, Timeout=1. The next B clears Timeout.
- S=1 on the same edge that cnt reaches TIMEOUT_CYC → normal result D=TIMEOUT_CYC>>1, Timeout=0.
- PULSE_CYC=4, S held high during FIRE → L high for 4 cycles, no early completion.
- Ignored input and mid-shot reset:
  - B pulsed while in WAIT → ignored.
  - Rst=0 mid-WAIT → next cycle L=0, Busy=0, D=0, Valid=0.
  - A later B starts a clean measurement.
